// File: rtl/cr_sync_filt.sv
// Multi-channel flip-flop synchroniser with per-channel debounce filter
// and registered rise/fall pulses on the filtered level.
module cr_sync_filt #(
   parameter int unsigned          pWidth      = 1,
   parameter int unsigned          pStages     = 2,
   parameter int unsigned          pFiltCycles = 4,
   parameter logic [pWidth-1:0]    pRstVal     = '0
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              En,
   input  logic [pWidth-1:0] D,
   output logic [pWidth-1:0] Q,
   output logic [pWidth-1:0] Rise,
   output logic [pWidth-1:0] Fall
);

   localparam int unsigned    CW       = $clog2(pFiltCycles + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(pFiltCycles - 1);

   generate
      if (pStages < 2) begin : g_bad_stages
         $error("cr_sync_filt: pStages must be >= 2");
      end
      if (pFiltCycles < 1) begin : g_bad_filt
         $error("cr_sync_filt: pFiltCycles must be >= 1");
      end
   endgenerate

   logic [pWidth-1:0] stage [pStages];
   logic [pWidth-1:0] s;
   logic [CW-1:0]     cnt   [pWidth];

   // Sync chain shifts every cycle; En only gates the filter counters.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int unsigned i = 0; i < pStages; i++) begin
            stage[i] <= pRstVal;
         end
      end else begin
         stage[0] <= D;
         for (int unsigned i = 1; i < pStages; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign s = stage[pStages-1];

   always_ff @(posedge Clk) begin
      if (Rst) begin
         Q    <= pRstVal;
         Rise <= '0;
         Fall <= '0;
         for (int unsigned c = 0; c < pWidth; c++) begin
            cnt[c] <= '0;
         end
      end else begin
         for (int unsigned c = 0; c < pWidth; c++) begin
            Rise[c] <= 1'b0;
            Fall[c] <= 1'b0;
            if (s[c] == Q[c]) begin
               cnt[c] <= '0;
            end else if (En) begin
               if (cnt[c] == CNT_LAST) begin
                  Q[c]    <= s[c];
                  cnt[c]  <= '0;
                  Rise[c] <= s[c];
                  Fall[c] <= ~s[c];
               end else begin
                  cnt[c] <= cnt[c] + CW'(1);
               end
            end
         end
      end
   end

endmodule
